// File: rtl/rr_bus_arbiter.sv
// Round-robin owner arbiter for one shared bus: one registered one-hot grant plus an encoded owner id.
// Optional forced release after MAX_HOLD ownership cycles is built when ARB_TIMEOUT_EN is defined.
module rr_bus_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_valid,
  output logic               timeout
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  localparam logic [ID_W-1:0] LAST_RESET = ID_W'(NUM_REQ - 1);

  logic [0:0]         state;
  logic [ID_W-1:0]    last_owner;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [ID_W-1:0]    pick_id;
  logic               pick_found;
  logic               owner_req;

  // Search starts one past the previous winner and wraps modulo NUM_REQ, not 2**ID_W.
  always_comb begin
    int idx;
    idx         = 0;
    pick_onehot = '0;
    pick_id     = '0;
    pick_found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_owner) + k) % NUM_REQ;
      if (!pick_found && req[idx]) begin
        pick_found       = 1'b1;
        pick_onehot      = '0;
        pick_onehot[idx] = 1'b1;
        pick_id          = ID_W'(idx);
      end
    end
  end

  assign owner_req = |(req & grant);

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      last_owner  <= LAST_RESET;
      hold_cnt    <= '0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant       <= pick_onehot;
            grant_id    <= pick_id;
            grant_valid <= 1'b1;
            last_owner  <= pick_id;
            hold_cnt    <= '0;
            state       <= OWN;
          end
        end
        OWN: begin
          // A voluntary release on the same edge wins over the forced one, so no pulse then.
          if (!owner_req) begin
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            state       <= IDLE;
          end else if (hold_cnt == HOLD_LAST) begin
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b1;
            state       <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  // Without the timeout feature MAX_HOLD has no effect on the hardware.
  logic [31:0] unused_max_hold;
  assign unused_max_hold = 32'(MAX_HOLD);
  assign timeout = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      last_owner  <= LAST_RESET;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant       <= pick_onehot;
            grant_id    <= pick_id;
            grant_valid <= 1'b1;
            last_owner  <= pick_id;
            state       <= OWN;
          end
        end
        OWN: begin
          if (!owner_req) begin
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Self-checking bench for rr_bus_arbiter: directed scenarios plus random requests
// against an owner/pointer reference model; follows ARB_TIMEOUT_EN like the RTL.
module tb_rr_bus_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int ID_W     = 2;
  localparam int MAX_HOLD = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               grant_valid;
  logic               timeout;

  int tests_run;
  int tests_failed;

  // Reference state: current owner (-1 = none), last winner, cycles owned, pulse
  int m_owner;
  int m_ptr;
  int m_hold;
  bit m_timeout;

  rr_bus_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .grant      (grant),
    .grant_id   (grant_id),
    .grant_valid(grant_valid),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic modelReset();
    m_owner   = -1;
    m_ptr     = NUM_REQ - 1;
    m_hold    = 0;
    m_timeout = 1'b0;
  endtask

  // One clock edge of the arbiter's rules, applied to the requests seen at that edge.
  task automatic modelStep(input logic [NUM_REQ-1:0] r);
    m_timeout = 1'b0;
    if (m_owner < 0) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int i;
        i = (m_ptr + k) % NUM_REQ;
        if (m_owner < 0 && r[i]) begin
          m_owner = i;
          m_ptr   = i;
          m_hold  = 0;
        end
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end else if (TIMEOUT_ON && m_hold == MAX_HOLD - 1) begin
      m_owner   = -1;
      m_timeout = 1'b1;
    end else begin
      m_hold++;
    end
  endtask

  task automatic checkAll();
    logic [NUM_REQ-1:0] exp_grant;
    int exp_id;
    exp_grant = (m_owner < 0) ? '0 : NUM_REQ'(1 << m_owner);
    exp_id    = (m_owner < 0) ? 0 : m_owner;
    checkOutput("grant", 32'(grant), 32'(exp_grant));
    checkOutput("grant_id", 32'(grant_id), 32'(exp_id));
    checkOutput("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
    checkOutput("timeout", 32'(timeout), 32'(m_timeout));
    checkOutput("onehot0", 32'($onehot0(grant)), 32'd1);
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] v);
    req = v;
    @(posedge clk);
    modelStep(v);
    #1;
    checkAll();
  endtask

  initial begin
    int ids[5];
    int run_len;
    bit broken;
    logic [NUM_REQ-1:0] r;

    tests_run    = 0;
    tests_failed = 0;
    modelReset();
    rst = 1'b0;
    req = 4'b1111;

    // Reset held with every requester active: nothing may be granted.
    repeat (10) begin
      @(posedge clk);
      #1;
      checkAll();
    end
    rst = 1'b1;
    applyStimulus(4'b1111);
    checkOutput("first_grant", 32'(grant), 32'b0001);
    applyStimulus(4'b0000);
    applyStimulus(4'b0000);

    // Single requester held for 5 cycles.
    repeat (5) applyStimulus(4'b0100);
    checkOutput("single_id", 32'(grant_id), 32'd2);
    applyStimulus(4'b0000);
    applyStimulus(4'b0000);

    // Fairness: everyone requests, each owner drops for one cycle after 3 cycles.
    for (int rnd = 0; rnd < 5; rnd++) begin
      applyStimulus(4'b1111);
      ids[rnd] = int'(grant_id);
      applyStimulus(4'b1111);
      applyStimulus(4'b1111);
      applyStimulus(4'b1111 & ~grant);
    end
    for (int rnd = 1; rnd < 5; rnd++)
      checkOutput("rr_order", 32'(ids[rnd]), 32'((ids[0] + rnd) % NUM_REQ));
    applyStimulus(4'b0000);

    // Wrap and skip: make 3 the last owner, then 1010 -> 1, then 3, then 0.
    applyStimulus(4'b1000);
    applyStimulus(4'b0000);
    applyStimulus(4'b1010);
    checkOutput("wrap_id1", 32'(grant_id), 32'd1);
    applyStimulus(4'b1010);
    applyStimulus(4'b1000);
    applyStimulus(4'b1000);
    checkOutput("skip_id3", 32'(grant_id), 32'd3);
    applyStimulus(4'b0000);
    applyStimulus(4'b0001);
    checkOutput("after_wrap", 32'(grant), 32'b0001);

    // No preemption: requester 2 pulses while 0 owns.
    applyStimulus(4'b0001);
    applyStimulus(4'b0101);
    applyStimulus(4'b0101);
    applyStimulus(4'b0001);
    applyStimulus(4'b0001);
    checkOutput("no_preempt", 32'(grant), 32'b0001);
    applyStimulus(4'b0000);

    // Hold limit: park the pointer on 3 so requester 0 wins first.
    applyStimulus(4'b1000);
    applyStimulus(4'b0000);
    run_len = 0;
    broken  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(4'b0011);
      if (!broken && grant == 4'b0001) run_len++;
      else broken = 1'b1;
    end
    checkOutput("hold_run", 32'(run_len), TIMEOUT_ON ? 32'd16 : 32'd40);
    applyStimulus(4'b0000);
    applyStimulus(4'b0000);

    // Random traffic with sticky requests so ownerships last a while.
    r = '0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) < 3) r = NUM_REQ'($urandom);
      if (c == 200) begin
        // Asynchronous reset while the bus may be owned.
        @(negedge clk);
        rst = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(posedge clk);
        #1;
        rst = 1'b1;
      end
      applyStimulus(r);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Safety net so the bench never hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/rr_bus_arbiter.md
Name: rr_bus_arbiter

Overview:
- Round-robin arbiter that shares one datapath/bus resource among NUM_REQ requesters; one owner at a time.
- Sits between the requesting engines and the shared resource. Drives a one-hot grant and an encoded owner ID for the resource-side mux.
- The owner keeps the grant for as long as it holds its request. Fairness comes from a rotating priority pointer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of grant_id; must satisfy 2**ID_W >= NUM_REQ
- MAX_HOLD, 16, maximum ownership cycles before forced release (used only with ARB_TIMEOUT_EN; must be >= 2)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-low reset; clk and rst named as in the rest of the codebase
- req  input  NUM_REQ  request lines, level; bit i = requester i
- grant  output  NUM_REQ  one-hot grant, registered; all-zero when no owner
- grant_id  output  ID_W  index of current owner; 0 when no owner
- grant_valid  output  1  high while any grant bit is high
- timeout  output  1  one-cycle pulse on forced release (ARB_TIMEOUT_EN only)

Behaviour:
- Reset (rst=0, async): grant=0, grant_id=0, grant_valid=0, timeout=0, state=IDLE, hold counter=0, last_owner=NUM_REQ-1, so the first search starts at requester 0.
- States:
  - IDLE: at each edge, if req!=0, pick the first set bit searching last_owner+1, last_owner+2, ... modulo NUM_REQ. Then register grant/grant_id, set grant_valid=1, last_owner=winner, go to OWN. If req==0, stay in IDLE.
  - OWN: at each edge, if req[owner]==1, keep the grant. If req[owner]==0, clear grant/grant_valid, set grant_id=0, go to IDLE.
- Latency:
  - req sampled at edge n gives grant visible after edge n (1 cycle).
  - The release edge is followed by at least one IDLE cycle. Back-to-back ownership therefore has exactly one dead cycle between owners.
- Arbitration uses only req sampled at the IDLE edge. A request raised and dropped while another requester owns the bus is not remembered.
- Requests from non-owners are ignored in OWN. No preemption except timeout.
- Simultaneous requests: the rotating pointer decides the winner. With all NUM_REQ requesting continuously, grant order is 0,1,2,3,0,...
- Wrap-around: last_owner=NUM_REQ-1 searches from 0.
- grant is always one-hot or zero; grant_id always equals the index of the set bit.
- Reset mid-ownership clears the grant immediately (async) and restores pointer reset values.
- Req bits at index >= NUM_REQ do not exist. Bit-width of the search wraps with a modulo on NUM_REQ, not 2**ID_W.

Optional Feature:
- Macro ARB_TIMEOUT_EN, placed in defines.v.
- Defined:
  - A hold counter resets to 0 on every grant and increments each OWN cycle.
  - When the counter equals MAX_HOLD-1 and req[owner] is still 1, the next edge force-releases: grant=0, go to IDLE, timeout=1 for exactly that one cycle.
  - The pointer has already advanced past the owner, so a continuously requesting owner is served again only after other requesters.
  - Normal release on the same edge takes precedence: timeout=0.
- Not defined: no counter logic; timeout tied to 0; ownership is unbounded.

Test Plan:
- Reset: hold rst=0 for 10 cycles with req=4'b1111, then release. Required: grant=0000, grant_id=0, grant_valid=0 during reset. After the first edge with rst=1: grant=0001, grant_id=0.
- Single requester: req=0100 for 5 cycles, then 0000. Required: grant=0100 and grant_id=2 from 1 cycle after req, held for 5 cycles. Cleared 1 cycle after req drops.
- Round-robin fairness: req=1111, each owner drops its bit for 1 cycle after 3 cycles of ownership. Required: grant sequence 0001, 0010, 0100, 1000, 0001 with one zero-grant cycle between each.
- Wrap and skip: last owner 3, then req=1010. Required: grant=0010 (id 1). Owner releases with req=1000 still set. Required: grant=1000 (id 3). Then req=0001 gives grant=0001.
- No preemption: owner 0 holds req; requester 2 pulses req for 2 cycles and drops. Required: grant stays 0001, and requester 2 is never granted.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=16): req=0011 held constant. Required: grant=0001 for exactly 16 cycles, then timeout=1 for 1 cycle with grant=0000, then grant=0010. Without the macro: grant=0001 indefinitely and timeout stays 0.
